// File: rtl/detag_shift_engine.sv
`default_nettype none
// ============================================================================
// Module  : detag_shift_engine
// Strips a runtime-sized tag from the head of each AXI-Stream packet and
// realigns the remaining payload; exports the tag and counts runt drops.
// Rev     : 1.0
// ============================================================================
module detag_shift_engine #(
    parameter int AXIS_BUS_WIDTH    = 64,
    parameter int AXIS_ID_WIDTH     = 4,
    parameter int MIN_TAG_SIZE_BITS = 32,
    parameter int MAX_TAG_SIZE_BITS = 64,
    parameter int CNT_WIDTH         = 16,
    localparam int N                = AXIS_BUS_WIDTH / 8,
    localparam int ROUTE_W          = 2 ** AXIS_ID_WIDTH,
    localparam int NUM_TAG_SIZES    = (MAX_TAG_SIZE_BITS - MIN_TAG_SIZE_BITS) / 16 + 2,
    localparam int MODE_W           = $clog2(NUM_TAG_SIZES)
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0]    axis_in_tdata,
    input  logic [N-1:0]                 axis_in_tkeep,
    input  logic [ROUTE_W:0]             axis_in_tuser,
    input  logic                         axis_in_tlast,
    input  logic                         axis_in_tvalid,
    output logic                         axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0]    axis_out_tdata,
    output logic [N-1:0]                 axis_out_tkeep,
    output logic [ROUTE_W-1:0]           axis_out_tuser,
    output logic                         axis_out_tlast,
    output logic                         axis_out_tvalid,
    input  logic                         axis_out_tready,
    output logic [MAX_TAG_SIZE_BITS-1:0] axis_out_tag,
    input  logic [MODE_W-1:0]            tag_mode,
    output logic [CNT_WIDTH-1:0]         runt_drop_count
);

    localparam int BC_W  = $clog2(N + 1);
    localparam int MIN_B = MIN_TAG_SIZE_BITS / 8;
    localparam int TAG_B = MAX_TAG_SIZE_BITS / 8;

    typedef enum logic [1:0] {
        ST_SOP    = 2'd0,
        ST_STRIP  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_BYPASS = 2'd3
    } state_t;

    function automatic logic [N-1:0] cnt2keep(input logic [BC_W-1:0] c);
        logic [N-1:0] k;
        for (int i = 0; i < N; i++) k[i] = (i < int'(c));
        return k;
    endfunction

    function automatic logic [AXIS_BUS_WIDTH-1:0] keep2mask(input logic [N-1:0] k);
        logic [AXIS_BUS_WIDTH-1:0] m;
        for (int i = 0; i < N; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    function automatic logic [MAX_TAG_SIZE_BITS-1:0] tag_mask(input logic [BC_W-1:0] c);
        logic [MAX_TAG_SIZE_BITS-1:0] m;
        for (int i = 0; i < TAG_B; i++) m[8*i +: 8] = {8{i < int'(c)}};
        return m;
    endfunction

    state_t                         state_q, state_d;
    logic [AXIS_BUS_WIDTH-1:0]      rem_data_q, rem_data_d;
    logic [BC_W-1:0]                rem_cnt_q, rem_cnt_d;
    logic [BC_W-1:0]                strip_q, strip_d;
    logic [ROUTE_W-1:0]             route_q, route_d;
    logic [MAX_TAG_SIZE_BITS-1:0]   tag_pend_q, tag_pend_d;
    logic [AXIS_BUS_WIDTH-1:0]      out_data_q, out_data_d;
    logic [N-1:0]                   out_keep_q, out_keep_d;
    logic [ROUTE_W-1:0]             out_user_q, out_user_d;
    logic                           out_last_q, out_last_d;
    logic                           out_valid_q, out_valid_d;
    logic [MAX_TAG_SIZE_BITS-1:0]   out_tag_q, out_tag_d;
    logic [CNT_WIDTH-1:0]           runt_cnt_q, runt_cnt_d;

    logic                           slot_free;
    logic                           in_fire;
    logic [BC_W-1:0]                in_cnt;
    logic [BC_W-1:0]                sel_strip;
    logic                           sel_bypass;
    logic [MAX_TAG_SIZE_BITS-1:0]   sel_tag;
    logic [AXIS_BUS_WIDTH-1:0]      sop_rem;
    logic [BC_W-1:0]                sop_rem_cnt;
    logic [AXIS_BUS_WIDTH-1:0]      mid_rem;
    logic [BC_W-1:0]                mid_rem_cnt;
    logic [BC_W-1:0]                k_lo;
    logic [BC_W-1:0]                strip_cnt;
    logic [AXIS_BUS_WIDTH-1:0]      rem_clean;

    // Held beats block both new input and the flush beat until the slice drains.
    assign slot_free      = !out_valid_q || axis_out_tready;
    assign axis_in_tready = aresetn && slot_free && (state_q != ST_FLUSH);
    assign in_fire        = axis_in_tvalid && axis_in_tready;

    always_comb begin
        in_cnt = '0;
        for (int i = 0; i < N; i++) in_cnt = in_cnt + BC_W'(axis_in_tkeep[i]);
    end

    always_comb begin
        sel_bypass  = (tag_mode == '0) || (int'(tag_mode) >= NUM_TAG_SIZES);
        sel_strip   = BC_W'(MIN_B + 2 * (int'(tag_mode) - 1));
        sel_tag     = axis_in_tdata[MAX_TAG_SIZE_BITS-1:0] & tag_mask(sel_strip);
        sop_rem     = axis_in_tdata >> {sel_strip, 3'b000};
        sop_rem_cnt = (in_cnt > sel_strip) ? (in_cnt - sel_strip) : '0;
        mid_rem     = axis_in_tdata >> {strip_q, 3'b000};
        mid_rem_cnt = (in_cnt > strip_q) ? (in_cnt - strip_q) : '0;
        k_lo        = (in_cnt < strip_q) ? in_cnt : strip_q;
        strip_cnt   = rem_cnt_q + k_lo;
        rem_clean   = rem_data_q & keep2mask(cnt2keep(rem_cnt_q));
    end

    always_comb begin
        state_d     = state_q;
        rem_data_d  = rem_data_q;
        rem_cnt_d   = rem_cnt_q;
        strip_d     = strip_q;
        route_d     = route_q;
        tag_pend_d  = tag_pend_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_user_d  = out_user_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !axis_out_tready;
        out_tag_d   = out_tag_q;
        runt_cnt_d  = runt_cnt_q;

        case (state_q)
            ST_SOP: begin
                if (in_fire) begin
                    route_d = axis_in_tuser[ROUTE_W-1:0];
                    if (sel_bypass || !axis_in_tuser[ROUTE_W]) begin
                        out_valid_d = 1'b1;
                        out_data_d  = axis_in_tdata;
                        out_keep_d  = axis_in_tkeep;
                        out_user_d  = axis_in_tuser[ROUTE_W-1:0];
                        out_last_d  = axis_in_tlast;
                        out_tag_d   = '0;
                        rem_cnt_d   = '0;
                        if (!axis_in_tlast) state_d = ST_BYPASS;
                    end else begin
                        strip_d    = sel_strip;
                        tag_pend_d = sel_tag;
                        rem_data_d = sop_rem;
                        rem_cnt_d  = sop_rem_cnt;
                        if (!axis_in_tlast) begin
                            state_d = ST_STRIP;
                        end else if (in_cnt > sel_strip) begin
                            // Single-beat packet: the remainder is the whole payload.
                            out_valid_d = 1'b1;
                            out_data_d  = sop_rem & keep2mask(cnt2keep(sop_rem_cnt));
                            out_keep_d  = cnt2keep(sop_rem_cnt);
                            out_user_d  = axis_in_tuser[ROUTE_W-1:0];
                            out_last_d  = 1'b1;
                            out_tag_d   = sel_tag;
                            rem_cnt_d   = '0;
                        end else begin
                            rem_cnt_d = '0;
                            if (runt_cnt_q != '1) runt_cnt_d = runt_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_STRIP: begin
                if (in_fire) begin
                    out_valid_d = 1'b1;
                    out_keep_d  = cnt2keep(strip_cnt);
                    out_data_d  = (rem_clean | (axis_in_tdata << {rem_cnt_q, 3'b000}))
                                  & keep2mask(cnt2keep(strip_cnt));
                    out_user_d  = route_q;
                    out_tag_d   = tag_pend_q;
                    out_last_d  = 1'b0;
                    rem_data_d  = mid_rem;
                    rem_cnt_d   = mid_rem_cnt;
                    if (axis_in_tlast) begin
                        if (in_cnt > strip_q) begin
                            state_d = ST_FLUSH;
                        end else begin
                            out_last_d = 1'b1;
                            rem_cnt_d  = '0;
                            state_d    = ST_SOP;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rem_clean;
                    out_keep_d  = cnt2keep(rem_cnt_q);
                    out_user_d  = route_q;
                    out_tag_d   = tag_pend_q;
                    out_last_d  = 1'b1;
                    rem_cnt_d   = '0;
                    state_d     = ST_SOP;
                end
            end
            ST_BYPASS: begin
                if (in_fire) begin
                    out_valid_d = 1'b1;
                    out_data_d  = axis_in_tdata;
                    out_keep_d  = axis_in_tkeep;
                    out_user_d  = route_q;
                    out_last_d  = axis_in_tlast;
                    out_tag_d   = '0;
                    if (axis_in_tlast) state_d = ST_SOP;
                end
            end
            default: state_d = ST_SOP;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_SOP;
            rem_data_q  <= '0;
            rem_cnt_q   <= '0;
            strip_q     <= '0;
            route_q     <= '0;
            tag_pend_q  <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_user_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            runt_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rem_data_q  <= rem_data_d;
            rem_cnt_q   <= rem_cnt_d;
            strip_q     <= strip_d;
            route_q     <= route_d;
            tag_pend_q  <= tag_pend_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_user_q  <= out_user_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            runt_cnt_q  <= runt_cnt_d;
        end
    end

    assign axis_out_tdata  = out_data_q;
    assign axis_out_tkeep  = out_keep_q;
    assign axis_out_tuser  = out_user_q;
    assign axis_out_tlast  = out_last_q;
    assign axis_out_tvalid = out_valid_q;
    assign axis_out_tag    = out_tag_q;
    assign runt_drop_count = runt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_detag_shift_engine.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for detag_shift_engine: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_detag_shift_engine;

    localparam int W      = 64;
    localparam int N      = 8;
    localparam int IDW    = 4;
    localparam int RW     = 16;
    localparam int MINB   = 32;
    localparam int MAXB   = 64;
    localparam int CNT_W  = 8;
    localparam int NT     = 4;
    localparam int MODE_W = 2;

    typedef struct packed {
        logic [W-1:0]    data;
        logic [N-1:0]    keep;
        logic            last;
        logic [RW-1:0]   user;
        logic [MAXB-1:0] tag;
    } beat_t;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [W-1:0]      axis_in_tdata = '0;
    logic [N-1:0]      axis_in_tkeep = '0;
    logic [RW:0]       axis_in_tuser = '0;
    logic              axis_in_tlast = 1'b0;
    logic              axis_in_tvalid = 1'b0;
    logic              axis_in_tready;
    logic [W-1:0]      axis_out_tdata;
    logic [N-1:0]      axis_out_tkeep;
    logic [RW-1:0]     axis_out_tuser;
    logic              axis_out_tlast;
    logic              axis_out_tvalid;
    logic              axis_out_tready = 1'b1;
    logic [MAXB-1:0]   axis_out_tag;
    logic [MODE_W-1:0] tag_mode = '0;
    logic [CNT_W-1:0]  runt_drop_count;

    int          checks = 0;
    int          errors = 0;
    int          exp_runt = 0;
    int          bp_mode = 0;
    beat_t       exp_q[$];
    logic [7:0]  pkt[$];
    beat_t       mon_e;
    beat_t       act_b;
    beat_t       prev_b;
    bit          prev_stall = 1'b0;

    detag_shift_engine #(
        .AXIS_BUS_WIDTH   (W),
        .AXIS_ID_WIDTH    (IDW),
        .MIN_TAG_SIZE_BITS(MINB),
        .MAX_TAG_SIZE_BITS(MAXB),
        .CNT_WIDTH        (CNT_W)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .axis_in_tdata   (axis_in_tdata),
        .axis_in_tkeep   (axis_in_tkeep),
        .axis_in_tuser   (axis_in_tuser),
        .axis_in_tlast   (axis_in_tlast),
        .axis_in_tvalid  (axis_in_tvalid),
        .axis_in_tready  (axis_in_tready),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tkeep  (axis_out_tkeep),
        .axis_out_tuser  (axis_out_tuser),
        .axis_out_tlast  (axis_out_tlast),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (axis_out_tready),
        .axis_out_tag    (axis_out_tag),
        .tag_mode        (tag_mode),
        .runt_drop_count (runt_drop_count)
    );

    always #5 aclk = ~aclk;

    // Output-side ready: 0 = always ready, 1 = random 50%, 2 = stalled.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            case (bp_mode)
                0:       axis_out_tready = 1'b1;
                1:       axis_out_tready = ($urandom_range(0, 1) == 1);
                default: axis_out_tready = 1'b0;
            endcase
        end
    end

    function automatic logic [W-1:0] kmask(input logic [N-1:0] k);
        logic [W-1:0] m;
        for (int i = 0; i < N; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    always @(negedge aclk) begin
        act_b = '{axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tuser, axis_out_tag};
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (act_b != prev_b) begin
                    errors++;
                    $display("FAIL stall_hold: got %h expected %h", act_b, prev_b);
                end
            end
            prev_stall = axis_out_tvalid && !axis_out_tready;
            prev_b     = act_b;
            if (axis_out_tvalid && axis_out_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected none", act_b);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ((act_b.data & kmask(mon_e.keep)) != mon_e.data || act_b.keep != mon_e.keep ||
                        act_b.last != mon_e.last || act_b.user != mon_e.user || act_b.tag != mon_e.tag) begin
                        errors++;
                        $display("FAIL out_beat: got data=%h keep=%h last=%b user=%h tag=%h expected data=%h keep=%h last=%b user=%h tag=%h",
                                 act_b.data, act_b.keep, act_b.last, act_b.user, act_b.tag,
                                 mon_e.data, mon_e.keep, mon_e.last, mon_e.user, mon_e.tag);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] d, input logic [N-1:0] k, input logic l,
                            input logic [RW-1:0] u, input logic [MAXB-1:0] t);
        beat_t e;
        e = '{d, k, l, u, t};
        exp_q.push_back(e);
    endtask

    // Software strip model: drop the first S bytes, re-chunk the rest into N-byte beats.
    task automatic model_pkt(input int mode, input bit present, input logic [RW-1:0] route);
        int len;
        int s;
        logic [MAXB-1:0] tag;
        beat_t e;
        len = pkt.size();
        if (mode == 0 || mode >= NT || !present) s = 0;
        else s = MINB / 8 + 2 * (mode - 1);
        if (s > 0 && len <= s) begin
            if (exp_runt != (1 << CNT_W) - 1) exp_runt++;
            return;
        end
        tag = '0;
        for (int i = 0; i < s; i++) tag[8*i +: 8] = pkt[i];
        for (int p = s; p < len; p += N) begin
            e = '0;
            for (int i = 0; i < N; i++) begin
                if (p + i < len) begin
                    e.data[8*i +: 8] = pkt[p+i];
                    e.keep[i] = 1'b1;
                end
            end
            e.last = (p + N >= len);
            e.user = route;
            e.tag  = tag;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_accept();
        int t;
        t = 0;
        @(negedge aclk);
        while (!axis_in_tready && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        if (!axis_in_tready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got tready=0 expected 1");
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_beat(input int b, input int mode, input bit present, input logic [RW-1:0] route);
        int len;
        int nb;
        len = pkt.size();
        nb  = (len + N - 1) / N;
        axis_in_tdata = '0;
        axis_in_tkeep = '0;
        for (int i = 0; i < N; i++) begin
            if (b * N + i < len) begin
                axis_in_tdata[8*i +: 8] = pkt[b*N+i];
                axis_in_tkeep[i] = 1'b1;
            end
        end
        axis_in_tuser  = {present, route};
        axis_in_tlast  = (b == nb - 1);
        axis_in_tvalid = 1'b1;
        // Mid-packet mode changes must be ignored.
        tag_mode = (b == 0) ? MODE_W'(mode) : MODE_W'(mode + 1);
        wait_accept();
    endtask

    task automatic send_pkt(input int mode, input bit present, input logic [RW-1:0] route, input bit use_model);
        int nb;
        nb = (pkt.size() + N - 1) / N;
        if (use_model) model_pkt(mode, present, route);
        for (int b = 0; b < nb; b++) drive_beat(b, mode, present, route);
        axis_in_tvalid = 1'b0;
    endtask

    task automatic fill(input int len);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(8'(i));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge aclk);
            t++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending beats expected 0", exp_q.size());
        end
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", 64'(axis_out_tvalid), 64'h0);
        chk("rst_tdata",  axis_out_tdata, 64'h0);
        chk("rst_tkeep",  64'(axis_out_tkeep), 64'h0);
        chk("rst_tag",    axis_out_tag, 64'h0);
        chk("rst_runt",   64'(runt_drop_count), 64'h0);
        chk("rst_tready", 64'(axis_in_tready), 64'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Bypass, mode 0
        fill(20);
        send_pkt(0, 1'b1, 16'hA5A5, 1'b1);

        // Strip 4 bytes, two full beats
        fill(16);
        push_exp(64'h0B0A090807060504, 8'hFF, 1'b0, 16'h0003, 64'h03020100);
        push_exp(64'h000000000F0E0D0C, 8'h0F, 1'b1, 16'h0003, 64'h03020100);
        send_pkt(1, 1'b1, 16'h0003, 1'b0);

        // Strip 6 bytes, last beat longer than the tag -> flush beat
        fill(15);
        push_exp(64'h0D0C0B0A09080706, 8'hFF, 1'b0, 16'h0100, 64'h050403020100);
        push_exp(64'h000000000000000E, 8'h01, 1'b1, 16'h0100, 64'h050403020100);
        send_pkt(2, 1'b1, 16'h0100, 1'b0);

        // Single-beat strip with payload
        fill(7);
        push_exp(64'h0000000000060504, 8'h07, 1'b1, 16'h8001, 64'h03020100);
        send_pkt(1, 1'b1, 16'h8001, 1'b0);

        // S = N
        fill(20);
        send_pkt(3, 1'b1, 16'h0F0F, 1'b1);

        // Tag not present -> passes unchanged
        fill(12);
        send_pkt(1, 1'b0, 16'h1234, 1'b1);
        wait_drain();

        // Runts
        fill(6);
        send_pkt(2, 1'b1, 16'h0001, 1'b1);
        chk("runt_one", 64'(runt_drop_count), 64'h1);
        fill(8);
        send_pkt(3, 1'b1, 16'h0001, 1'b1);
        chk("runt_two", 64'(runt_drop_count), 64'h2);

        // Random backpressure, mixed lengths and modes
        bp_mode = 1;
        for (int p = 0; p < 40; p++) begin
            fill($urandom_range(9, 200));
            send_pkt($urandom_range(0, 3), ($urandom_range(0, 3) != 0), 16'($urandom), 1'b1);
        end
        wait_drain();
        chk("runt_after_bp", 64'(runt_drop_count), 64'(exp_runt));

        // Reset while in STRIP with a held output beat
        bp_mode = 2;
        @(posedge aclk);
        #1;
        fill(24);
        drive_beat(0, 1, 1'b1, 16'h0042);
        drive_beat(1, 1, 1'b1, 16'h0042);
        axis_in_tvalid = 1'b0;
        chk("pre_rst_tvalid", 64'(axis_out_tvalid), 64'h1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("midrst_tvalid", 64'(axis_out_tvalid), 64'h0);
        chk("midrst_tdata",  axis_out_tdata, 64'h0);
        chk("midrst_tag",    axis_out_tag, 64'h0);
        chk("midrst_runt",   64'(runt_drop_count), 64'h0);
        chk("midrst_tready", 64'(axis_in_tready), 64'h0);
        exp_runt = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        bp_mode = 1;
        @(posedge aclk);
        #1;
        fill(17);
        push_exp(64'h0D0C0B0A09080706, 8'hFF, 1'b0, 16'h0077, 64'h050403020100);
        push_exp(64'h0000000000100F0E, 8'h07, 1'b1, 16'h0077, 64'h050403020100);
        send_pkt(2, 1'b1, 16'h0077, 1'b0);
        wait_drain();

        // Runt counter saturation
        bp_mode = 0;
        for (int r = 0; r < (1 << CNT_W) + 5; r++) begin
            fill(4);
            send_pkt(1, 1'b1, 16'h0002, 1'b1);
        end
        chk("runt_sat", 64'(runt_drop_count), 64'hFF);

        fill(10);
        send_pkt(1, 1'b1, 16'h0005, 1'b1);
        wait_drain();
        repeat (3) @(posedge aclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
